// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : instr_sequencer
//  Purpose  : Multi-cycle fetch/decode/execute sequencer for the tau core.
//             Steps LOAD (0000) and STORE (1111) through one datapath phase
//             per cycle. Waits on a memory ready handshake, flags illegal
//             opcodes and memory timeouts with a sticky fault code, and
//             counts retired instructions.
//  Ports    : clk, rst (sync, active-high), run, opcode[3:0], mem_ready
//             -> alu_op[3:0], pc_load, ir_load, mem_read, mem_write,
//                reg_write, addr_sel, busy, fault[1:0],
//                instr_count[CNT_WIDTH-1:0]
//  Revision : 1.0  initial release
// ============================================================================
module instr_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [3:0]           opcode,
    input  logic                 mem_ready,
    output logic [3:0]           alu_op,
    output logic                 pc_load,
    output logic                 ir_load,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic                 addr_sel,
    output logic                 busy,
    output logic [1:0]           fault,
    output logic [CNT_WIDTH-1:0] instr_count
);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_fetch     = 3'd1;
    localparam logic [2:0] c_st_decode    = 3'd2;
    localparam logic [2:0] c_st_load_mem  = 3'd3;
    localparam logic [2:0] c_st_wb        = 3'd4;
    localparam logic [2:0] c_st_store_mem = 3'd5;
    localparam logic [2:0] c_st_fault     = 3'd6;

    localparam logic [3:0] c_op_load  = 4'b0000;
    localparam logic [3:0] c_op_store = 4'b1111;
    localparam logic [3:0] c_alu_pass = 4'b0110;

    localparam logic [1:0] c_fault_none    = 2'b00;
    localparam logic [1:0] c_fault_illegal = 2'b01;
    localparam logic [1:0] c_fault_timeout = 2'b10;

    localparam int                c_wait_w    = $clog2(MEM_TIMEOUT);
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(MEM_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic [c_wait_w-1:0]  r_wait;
    logic [1:0]           r_fault;
    logic [1:0]           w_next_fault;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_retire;
    logic                 w_mem_phase;
    logic                 w_wait_done;

    assign w_mem_phase = (r_state == c_st_fetch) || (r_state == c_st_load_mem) ||
                         (r_state == c_st_store_mem);
    // Last allowed waiting cycle; a ready on this same cycle still wins.
    assign w_wait_done = (r_wait == c_wait_last);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_fault = r_fault;
        w_retire     = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (run) w_next_state = c_st_fetch;
            end
            c_st_fetch: begin
                if (mem_ready) begin
                    w_next_state = c_st_decode;
                end else if (w_wait_done) begin
                    w_next_state = c_st_fault;
                    w_next_fault = c_fault_timeout;
                end
            end
            c_st_decode: begin
                if (opcode == c_op_load) begin
                    w_next_state = c_st_load_mem;
                end else if (opcode == c_op_store) begin
                    w_next_state = c_st_store_mem;
                end else begin
                    w_next_state = c_st_fault;
                    w_next_fault = c_fault_illegal;
                end
            end
            c_st_load_mem: begin
                if (mem_ready) begin
                    w_next_state = c_st_wb;
                end else if (w_wait_done) begin
                    w_next_state = c_st_fault;
                    w_next_fault = c_fault_timeout;
                end
            end
            c_st_wb: begin
                w_retire     = 1'b1;
                w_next_state = run ? c_st_fetch : c_st_idle;
            end
            c_st_store_mem: begin
                if (mem_ready) begin
                    w_retire     = 1'b1;
                    w_next_state = run ? c_st_fetch : c_st_idle;
                end else if (w_wait_done) begin
                    w_next_state = c_st_fault;
                    w_next_fault = c_fault_timeout;
                end
            end
            c_st_fault: begin
                w_next_state = c_st_fault;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, wait counter, fault and retire counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_wait  <= '0;
            r_fault <= c_fault_none;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_fault <= w_next_fault;
            if (w_retire) r_count <= r_count + c_cnt_one;
            // Remaining in a memory phase means mem_ready was low and the
            // timeout did not fire; any transition restarts the count.
            if (w_mem_phase && (w_next_state == r_state)) r_wait <= r_wait + 1'b1;
            else                                          r_wait <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Output decode (ir_load/pc_load also qualified by mem_ready)
    // ------------------------------------------------------------------
    always_comb begin
        alu_op    = 4'b0000;
        pc_load   = 1'b0;
        ir_load   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        addr_sel  = 1'b0;
        case (r_state)
            c_st_fetch: begin
                mem_read = 1'b1;
                ir_load  = mem_ready;
                pc_load  = mem_ready;
            end
            c_st_load_mem: begin
                mem_read = 1'b1;
                addr_sel = 1'b1;
                alu_op   = c_alu_pass;
            end
            c_st_wb: begin
                reg_write = 1'b1;
                alu_op    = c_alu_pass;
            end
            c_st_store_mem: begin
                mem_write = 1'b1;
                addr_sel  = 1'b1;
                alu_op    = c_alu_pass;
            end
            default: begin
            end
        endcase
    end

    assign busy        = (r_state != c_st_idle) && (r_state != c_st_fault);
    assign fault       = r_fault;
    assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_sequencer
//  Purpose  : Self-checking bench for instr_sequencer: directed vector
//             table, hand-written corner sequences and randomized cycles
//             compared against a phase-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_sequencer;

    localparam int TMO = 16;
    localparam int CW  = 4;   // narrow counter so wrap-around is reachable

    logic          clk = 1'b0;
    logic          rst, run, mem_ready;
    logic [3:0]    opcode;
    logic [3:0]    alu_op;
    logic          pc_load, ir_load, mem_read, mem_write, reg_write, addr_sel, busy;
    logic [1:0]    fault;
    logic [CW-1:0] instr_count;

    always #5 clk = ~clk;

    instr_sequencer #(.MEM_TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .alu_op(alu_op), .pc_load(pc_load), .ir_load(ir_load), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .addr_sel(addr_sel),
        .busy(busy), .fault(fault), .instr_count(instr_count)
    );

    int checks   = 0;
    int failures = 0;

    // Strobe bundle order: {pc_load, ir_load, mem_read, mem_write, reg_write, addr_sel, busy}
    localparam logic [6:0] S_IDLE = 7'b0000000;
    localparam logic [6:0] S_FRDY = 7'b1110001;
    localparam logic [6:0] S_DEC  = 7'b0000001;
    localparam logic [6:0] S_LDM  = 7'b0010011;
    localparam logic [6:0] S_WB   = 7'b0000101;
    localparam logic [6:0] S_STM  = 7'b0001011;

    function automatic logic [31:0] pack(input logic [3:0] a, input logic [6:0] s,
                                         input logic [1:0] f, input logic [CW-1:0] c);
        return {15'b0, a, s, f, c};
    endfunction

    function automatic logic [31:0] dut_vec();
        return pack(alu_op, {pc_load, ir_load, mem_read, mem_write, reg_write, addr_sel, busy},
                    fault, instr_count);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (instruction-phase view) ----------
    // step: -1 idle, 0 fetch, 1 decode, 2 memory access, 3 writeback, 9 faulted
    int         m_step  = -1;
    bit         m_store = 0;
    int         m_wait  = 0;
    logic [1:0] m_fault = 2'b00;
    int         m_count = 0;

    function automatic logic [31:0] model_vec(input logic rdy);
        logic [3:0] a = 4'd0;
        logic [6:0] s = 7'd0;
        case (m_step)
            0: s = rdy ? S_FRDY : 7'b0010001;
            1: s = S_DEC;
            2: begin s = m_store ? S_STM : S_LDM; a = 4'd6; end
            3: begin s = S_WB; a = 4'd6; end
            default: s = S_IDLE;
        endcase
        return pack(a, s, m_fault, CW'(m_count));
    endfunction

    task automatic model_update(input logic r, input logic rn, input logic [3:0] op,
                                input logic rd);
        if (r) begin
            m_step = -1; m_wait = 0; m_fault = 2'b00; m_count = 0;
        end else begin
            case (m_step)
                -1: if (rn) begin m_step = 0; m_wait = 0; end
                0, 2: begin
                    if (rd) begin
                        if (m_step == 0) m_step = 1;
                        else if (!m_store) m_step = 3;
                        else begin
                            m_count = (m_count + 1) % (1 << CW);
                            m_step  = rn ? 0 : -1;
                            m_wait  = 0;
                        end
                    end else if (m_wait == TMO - 1) begin
                        m_step = 9; m_fault = 2'b10;
                    end else begin
                        m_wait++;
                    end
                end
                1: begin
                    if (op == 4'h0)      begin m_step = 2; m_store = 0; m_wait = 0; end
                    else if (op == 4'hF) begin m_step = 2; m_store = 1; m_wait = 0; end
                    else                 begin m_step = 9; m_fault = 2'b01; end
                end
                3: begin
                    m_count = (m_count + 1) % (1 << CW);
                    m_step  = rn ? 0 : -1;
                    m_wait  = 0;
                end
                default: ;
            endcase
        end
    endtask

    // ---------------- cycle helpers ----------------
    task automatic apply(input logic r, input logic rn, input logic [3:0] op, input logic rd);
        rst = r; run = rn; opcode = op; mem_ready = rd;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        model_update(rst, run, opcode, mem_ready);
        @(negedge clk);
    endtask

    task automatic cyc(input string name, input logic r, input logic rn,
                       input logic [3:0] op, input logic rd);
        apply(r, rn, op, rd);
        check(name, dut_vec(), model_vec(rd));
        advance();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       r, rn;
        logic [3:0] op;
        logic       rd;
        logic [3:0] alu;
        logic [6:0] stb;
        logic [1:0] flt;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl[13];

    initial begin
        // Reset, then LOAD back-to-back into a STORE with three wait cycles.
        tbl[0]  = '{1'b0, 1'b1, 4'h0, 1'b1, 4'd0, S_IDLE,     2'd0, 4'd0};
        tbl[1]  = '{1'b0, 1'b1, 4'h0, 1'b1, 4'd0, S_FRDY,     2'd0, 4'd0};
        tbl[2]  = '{1'b0, 1'b1, 4'h0, 1'b1, 4'd0, S_DEC,      2'd0, 4'd0};
        tbl[3]  = '{1'b0, 1'b1, 4'h0, 1'b1, 4'd6, S_LDM,      2'd0, 4'd0};
        tbl[4]  = '{1'b0, 1'b1, 4'h0, 1'b1, 4'd6, S_WB,       2'd0, 4'd0};
        tbl[5]  = '{1'b0, 1'b0, 4'hF, 1'b1, 4'd0, S_FRDY,     2'd0, 4'd1};
        tbl[6]  = '{1'b0, 1'b0, 4'hF, 1'b0, 4'd0, S_DEC,      2'd0, 4'd1};
        tbl[7]  = '{1'b0, 1'b0, 4'hF, 1'b0, 4'd6, S_STM,      2'd0, 4'd1};
        tbl[8]  = '{1'b0, 1'b0, 4'hF, 1'b0, 4'd6, S_STM,      2'd0, 4'd1};
        tbl[9]  = '{1'b0, 1'b0, 4'hF, 1'b0, 4'd6, S_STM,      2'd0, 4'd1};
        tbl[10] = '{1'b0, 1'b0, 4'hF, 1'b1, 4'd6, S_STM,      2'd0, 4'd1};
        tbl[11] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'd0, S_IDLE,     2'd0, 4'd2};
        tbl[12] = '{1'b0, 1'b0, 4'h0, 1'b1, 4'd0, S_IDLE,     2'd0, 4'd2};

        apply(1'b1, 1'b0, 4'h0, 1'b0);
        advance();
        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].r, tbl[i].rn, tbl[i].op, tbl[i].rd);
            check($sformatf("tbl[%0d]", i), dut_vec(),
                  pack(tbl[i].alu, tbl[i].stb, tbl[i].flt, tbl[i].cnt));
            advance();
        end

        // ---- illegal opcode: sticky fault, run ignored, rst clears ----
        cyc("ill_rst", 1'b1, 1'b0, 4'h0, 1'b0);
        cyc("ill_idle", 1'b0, 1'b1, 4'h0, 1'b1);
        cyc("ill_fetch", 1'b0, 1'b1, 4'h0, 1'b1);
        cyc("ill_decode", 1'b0, 1'b1, 4'h5, 1'b1);
        check("ill_fault", dut_vec(), pack(4'd0, S_IDLE, 2'b01, 4'd0));
        for (int i = 0; i < 20; i++) cyc("ill_hold", 1'b0, 1'b1, 4'h0, 1'($urandom_range(0, 1)));
        check("ill_still", dut_vec(), pack(4'd0, S_IDLE, 2'b01, 4'd0));
        cyc("ill_clear", 1'b1, 1'b1, 4'h0, 1'b0);
        check("ill_cleared", dut_vec(), pack(4'd0, S_IDLE, 2'b00, 4'd0));

        // ---- fetch timeout after MEM_TIMEOUT waiting cycles ----
        cyc("tmo_idle", 1'b0, 1'b1, 4'h0, 1'b0);
        for (int i = 0; i < TMO; i++) cyc("tmo_wait", 1'b0, 1'b0, 4'h0, 1'b0);
        check("tmo_fault", dut_vec(), pack(4'd0, S_IDLE, 2'b10, 4'd0));

        // ---- ready on the last allowed cycle wins ----
        cyc("edge_rst", 1'b1, 1'b0, 4'h0, 1'b0);
        cyc("edge_idle", 1'b0, 1'b1, 4'h0, 1'b0);
        for (int i = 0; i < TMO - 1; i++) cyc("edge_wait", 1'b0, 1'b0, 4'h0, 1'b0);
        cyc("edge_ready", 1'b0, 1'b0, 4'h0, 1'b1);
        check("edge_decode", dut_vec(), pack(4'd0, S_DEC, 2'b00, 4'd0));

        // ---- counter wrap; run dropped during LOAD_MEM still retires ----
        cyc("wrap_rst", 1'b1, 1'b0, 4'h0, 1'b0);
        cyc("wrap_idle", 1'b0, 1'b1, 4'h0, 1'b1);
        for (int i = 0; i < (1 << CW) - 1; i++) begin
            cyc("wrap_f", 1'b0, 1'b1, 4'h0, 1'b1);
            cyc("wrap_d", 1'b0, 1'b1, 4'h0, 1'b1);
            cyc("wrap_m", 1'b0, 1'b1, 4'h0, 1'b1);
            cyc("wrap_w", 1'b0, 1'b1, 4'h0, 1'b1);
        end
        check("wrap_full", 32'(instr_count), 32'((1 << CW) - 1));
        cyc("drop_f", 1'b0, 1'b1, 4'h0, 1'b1);
        cyc("drop_d", 1'b0, 1'b1, 4'h0, 1'b1);
        cyc("drop_m0", 1'b0, 1'b0, 4'h0, 1'b0);
        cyc("drop_m1", 1'b0, 1'b0, 4'h0, 1'b1);
        cyc("drop_wb", 1'b0, 1'b0, 4'h0, 1'b1);
        check("wrap_zero_idle", dut_vec(), pack(4'd0, S_IDLE, 2'b00, 4'd0));

        // ---- reset while STORE_MEM is waiting ----
        cyc("srst_idle", 1'b0, 1'b1, 4'hF, 1'b1);
        cyc("srst_f0", 1'b0, 1'b1, 4'hF, 1'b1);
        cyc("srst_d0", 1'b0, 1'b1, 4'hF, 1'b1);
        cyc("srst_s0", 1'b0, 1'b1, 4'hF, 1'b1);
        cyc("srst_f1", 1'b0, 1'b1, 4'hF, 1'b1);
        cyc("srst_d1", 1'b0, 1'b1, 4'hF, 1'b1);
        cyc("srst_w0", 1'b0, 1'b1, 4'hF, 1'b0);
        cyc("srst_w1", 1'b0, 1'b1, 4'hF, 1'b0);
        cyc("srst_hit", 1'b1, 1'b1, 4'hF, 1'b0);
        check("srst_after", dut_vec(), pack(4'd0, S_IDLE, 2'b00, 4'd0));

        // ---- randomized cycles against the reference model ----
        for (int i = 0; i < 4000; i++) begin
            logic       r, rn, rd;
            logic [3:0] op;
            int         sel;
            r   = ($urandom_range(0, 149) == 0);
            rn  = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 9) < 7);
            sel = $urandom_range(0, 19);
            op  = (sel < 9) ? 4'h0 : (sel < 18) ? 4'hF : 4'($urandom_range(0, 15));
            cyc("rand", r, rn, op, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle fetch/decode/execute sequencer for the tau core. It drives the datapath strobes (pc_load, ir_load, mem_read, mem_write, reg_write, alu_op) one phase per cycle for the LOAD (0000) and STORE (1111) instructions. It waits on a memory ready handshake, flags illegal opcodes and memory timeouts, and counts retired instructions. It sits between the instruction register, PC, memory port and register file.

Parameters:
MEM_TIMEOUT, 16, max consecutive cycles a memory phase may wait with mem_ready low before faulting (>=2)
CNT_WIDTH, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
run  input  1  1 = sequence instructions; sampled in IDLE and at instruction retire
opcode  input  4  IR[7:4], valid from the cycle after ir_load
mem_ready  input  1  memory completes current read/write this cycle
alu_op  output  4  ALU function; 0110 (pass/address) in LOAD_MEM, STORE_MEM, WB; else 0000
pc_load  output  1  PC increment strobe
ir_load  output  1  IR capture strobe
mem_read  output  1  memory read request
mem_write  output  1  memory write request
reg_write  output  1  register-file write strobe
addr_sel  output  1  0 = PC drives memory address, 1 = operand address
busy  output  1  1 in any state except IDLE and FAULT
fault  output  2  00 none, 01 illegal opcode, 10 memory timeout; sticky
instr_count  output  CNT_WIDTH  retired instructions, wraps at 2^CNT_WIDTH

Behaviour:
- Reset: state IDLE; all strobes 0, alu_op 0000, addr_sel 0, fault 00, instr_count 0, wait counter 0. rst overrides everything, including mid-memory-phase; an outstanding request is dropped the same edge.
- All outputs are decoded from state. ir_load/pc_load are additionally qualified by mem_ready (Mealy). No output ever drives Z; inactive = 0.
- IDLE: all strobes 0. run=1 -> FETCH next edge.
- FETCH: mem_read=1, addr_sel=0. If mem_ready=1: ir_load=1 and pc_load=1 in that same cycle, -> DECODE.
- DECODE (1 cycle, no strobes): opcode 0000 -> LOAD_MEM; 1111 -> STORE_MEM; any other -> FAULT with fault=01.
- LOAD_MEM: mem_read=1, addr_sel=1, alu_op=0110. mem_ready=1 -> WB.
- WB: reg_write=1 for exactly one cycle, alu_op=0110, instr_count+1. Next: FETCH if run=1, else IDLE.
- STORE_MEM: mem_write=1, addr_sel=1, alu_op=0110. mem_ready=1 -> instr_count+1; FETCH if run=1, else IDLE.
- Wait counter: cleared on entry to FETCH, LOAD_MEM and STORE_MEM. Increments each cycle in those states while mem_ready=0. If mem_ready=0 with counter = MEM_TIMEOUT-1, go to FAULT with fault=10. mem_ready=1 on that same cycle wins and proceeds normally.
- FAULT: all strobes 0, busy 0, fault held. Exit only via rst. run is ignored.
- run deasserting mid-instruction does not abort it; the instruction completes and retires.
- Zero-wait latency (run=1 to retire): LOAD 4 cycles (FETCH, DECODE, LOAD_MEM, WB); STORE 3 cycles. Back-to-back instructions have no idle bubble.
- Exactly one of mem_read/mem_write/reg_write is high in any cycle (or none).
- instr_count wraps from all-ones to 0 without affecting state.

Test Plan:
- Reset then run=1, mem_ready tied 1, opcode=0000: strobes over 4 cycles are {mem_read, ir_load, pc_load} -> {} -> {mem_read, addr_sel, alu_op=0110} -> {reg_write}; instr_count=1, then FETCH again.
- STORE with opcode=1111, mem_ready low 3 cycles in STORE_MEM: mem_write held 4 cycles, never with reg_write; retire on 4th; instr_count+1.
- opcode=0101 in DECODE: next cycle fault=01, busy=0, all strobes 0. Holds for 20 cycles despite run=1. rst restores IDLE with fault=00.
- mem_ready held 0 in FETCH: mem_read high 16 cycles, then FAULT with fault=10. Repeat with mem_ready=1 on the 16th cycle: proceeds to DECODE, no fault.
- run dropped during LOAD_MEM: LOAD completes through WB, then IDLE. instr_count preset near 0xFFFF wraps to 0x0000 at retire.
- rst asserted during a waiting STORE_MEM: next cycle mem_write=0, state IDLE, instr_count=0.
